// File: rtl/sensor_scan_ctrl.sv
// Periodic sensor-bank scanner: samples every PERIOD cycles, confirms CONFIRM
// consecutive error samples before raising a latched, acknowledgeable alarm.
module sensor_scan_ctrl #(
  parameter int unsigned PERIOD  = 10,
  parameter int unsigned CONFIRM = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] sensors,
  input  logic       ack,
  output logic       sample_tick,
  output logic       error_now,
  output logic       alarm,
  output logic [3:0] alarm_sensors,
  output logic [7:0] alarm_cnt
);

  localparam logic [7:0] TIMER_MAX = 8'(PERIOD - 1);
  localparam logic [3:0] CONF_HITS = 4'(CONFIRM);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CONFIRM, S_ALARM} state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] hits_q, hits_d;
  logic       tick_q, tick_d;
  logic       err_q, err_d;
  logic       alarm_q, alarm_d;
  logic [3:0] asens_q, asens_d;
  logic [7:0] cnt_q, cnt_d;

  logic       sample;
  logic       err_in;
  logic       raise;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hits_d  = hits_q;
    tick_d  = 1'b0;
    err_d   = err_q;
    alarm_d = alarm_q;
    asens_d = asens_q;
    cnt_d   = cnt_q;
    raise   = 1'b0;

    sample = enable && (timer_q == TIMER_MAX);
    err_in = sensors[0] | (sensors[1] & (sensors[2] | sensors[3]));

    if (!enable || sample) timer_d = '0;
    else                   timer_d = timer_q + 8'd1;

    if (sample) begin
      tick_d = 1'b1;
      err_d  = err_in;
    end

    case (state_q)
      S_IDLE: begin
        hits_d = '0;
        if (enable) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!enable) begin
          state_d = S_IDLE;
          hits_d  = '0;
        end else if (sample && err_in) begin
          if (CONF_HITS == 4'd1) raise = 1'b1;
          else begin
            state_d = S_CONFIRM;
            hits_d  = 4'd1;
          end
        end
      end
      S_CONFIRM: begin
        if (!enable) begin
          state_d = S_IDLE;
          hits_d  = '0;
        end else if (sample) begin
          if (!err_in) begin
            state_d = S_SCAN;
            hits_d  = '0;
          end else if (hits_q + 4'd1 == CONF_HITS) raise = 1'b1;
          else hits_d = hits_q + 4'd1;
        end
      end
      S_ALARM: begin
        // err_q is the pre-edge value, so an ack landing on a sample edge
        // is judged against the previous sample.
        if (ack && !err_q) begin
          state_d = enable ? S_SCAN : S_IDLE;
          alarm_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (raise) begin
      state_d = S_ALARM;
      alarm_d = 1'b1;
      asens_d = sensors;
      hits_d  = '0;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      hits_q  <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
      asens_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hits_q  <= hits_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      alarm_q <= alarm_d;
      asens_q <= asens_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sample_tick   = tick_q;
  assign error_now     = err_q;
  assign alarm         = alarm_q;
  assign alarm_sensors = asens_q;
  assign alarm_cnt     = cnt_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Bench for sensor_scan_ctrl: PERIOD=4 with CONFIRM=3 (dut) and CONFIRM=1 (dut1),
// expected per-sample results queued at stimulus time and popped on sample_tick.
module tb_sensor_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, ack;
  logic [3:0] sensors;

  logic       tick0, err0, alarm0;
  logic [3:0] asens0;
  logic [7:0] cnt0;
  logic       tick1, err1, alarm1;
  logic [3:0] asens1;
  logic [7:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;
  exp_t exp_q[$];

  sensor_scan_ctrl #(.PERIOD(4), .CONFIRM(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .ack(ack),
    .sample_tick(tick0), .error_now(err0), .alarm(alarm0),
    .alarm_sensors(asens0), .alarm_cnt(cnt0)
  );

  sensor_scan_ctrl #(.PERIOD(4), .CONFIRM(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .ack(ack),
    .sample_tick(tick1), .error_now(err1), .alarm(alarm1),
    .alarm_sensors(asens1), .alarm_cnt(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] pk(input logic e, input logic a,
                                     input logic [3:0] s, input logic [7:0] c);
    return {e, a, s, c};
  endfunction

  task automatic do_reset();
    enable  = 1'b0;
    ack     = 1'b0;
    sensors = 4'd0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait for the next sample_tick, observed at a falling edge.
  task automatic wait_sample(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (tick0 !== 1'b1 && cyc < 20);
    n_checks++;
    if (tick0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sample_timeout: sample_tick=%b after %0d cycles, need 1", tick0, cyc);
    end
  endtask

  task automatic test_reset();
    int cyc;
    do_reset();
    n_checks++;
    if ({tick0, err0, alarm0, asens0, cnt0} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h, need 0", {tick0, err0, alarm0, asens0, cnt0});
    end
    enable  = 1'b1;
    sensors = 4'b0001;
    repeat (3) wait_sample(cyc);
    n_checks++;
    if (alarm0 !== 1'b1 || cnt0 !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset_alarm: alarm=%b cnt=%0d, need alarm=1 cnt=1", alarm0, cnt0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tick0, err0, alarm0, asens0, cnt0, tick1, err1, alarm1, asens1, cnt1} !== 30'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h, need 0/0",
               {tick0, err0, alarm0, asens0, cnt0}, {tick1, err1, alarm1, asens1, cnt1});
    end
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_first_sample();
    int cyc;
    do_reset();
    enable = 1'b1;
    wait_sample(cyc);
    n_checks++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL first_sample_latency: got %0d cycles, need 4", cyc);
    end
  endtask

  task automatic test_confirm_alarm();
    int   cyc;
    exp_t e;
    do_reset();
    exp_q.push_back('{name: "confirm_s1", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "confirm_s2", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "confirm_s3", v: pk(1'b1, 1'b1, 4'b0001, 8'd1)});
    sensors = 4'b0001;
    enable  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_sample(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({err0, alarm0, asens0, cnt0} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h, need %h", e.name, {err0, alarm0, asens0, cnt0}, e.v);
      end
      n_checks++;
      if (cyc != 4) begin
        n_fail++;
        $display("FAIL confirm_tick_period_%0d: got %0d cycles, need 4", i, cyc);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tick0 !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_width: sample_tick=%b one cycle later, need 0", tick0);
    end
  endtask

  task automatic test_ack();
    int   cyc;
    exp_t e;
    exp_q.push_back('{name: "ack_err_sample", v: pk(1'b1, 1'b1, 4'b0001, 8'd1)});
    exp_q.push_back('{name: "ack_clear_sample", v: pk(1'b0, 1'b1, 4'b0001, 8'd1)});
    sensors = 4'b1010;
    wait_sample(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if ({err0, alarm0, asens0, cnt0} !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", e.name, {err0, alarm0, asens0, cnt0}, e.v);
    end
    ack = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (alarm0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_ignored: alarm=%b, need 1", alarm0);
    end
    ack     = 1'b0;
    sensors = 4'b0000;
    wait_sample(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if ({err0, alarm0, asens0, cnt0} !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", e.name, {err0, alarm0, asens0, cnt0}, e.v);
    end
    ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (alarm0 !== 1'b0 || cnt0 !== 8'd1) begin
      n_fail++;
      $display("FAIL ack_exit: alarm=%b cnt=%0d, need alarm=0 cnt=1", alarm0, cnt0);
    end
    ack = 1'b0;
  endtask

  task automatic test_ack_on_sample();
    int   cyc;
    exp_t e;
    exp_q.push_back('{name: "edge_s1", v: pk(1'b1, 1'b0, 4'b0001, 8'd1)});
    exp_q.push_back('{name: "edge_s2", v: pk(1'b1, 1'b0, 4'b0001, 8'd1)});
    exp_q.push_back('{name: "edge_s3", v: pk(1'b1, 1'b1, 4'b0001, 8'd2)});
    sensors = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      wait_sample(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({err0, alarm0, asens0, cnt0} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h, need %h", e.name, {err0, alarm0, asens0, cnt0}, e.v);
      end
    end
    exp_q.push_back('{name: "edge_ack_sample", v: pk(1'b0, 1'b1, 4'b0001, 8'd2)});
    sensors = 4'b0000;
    repeat (3) @(negedge clk);
    ack = 1'b1;
    wait_sample(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if ({err0, alarm0, asens0, cnt0} !== e.v || cyc != 1) begin
      n_fail++;
      $display("FAIL %s: got %h after %0d cycles, need %h after 1",
               e.name, {err0, alarm0, asens0, cnt0}, cyc, e.v);
    end
    @(negedge clk);
    n_checks++;
    if (alarm0 !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_ack_exit: alarm=%b, need 0", alarm0);
    end
    ack = 1'b0;
  endtask

  task automatic test_no_alarm();
    int         cyc;
    exp_t       e;
    logic [3:0] stim [6];
    stim = '{4'b0110, 4'b0110, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
    do_reset();
    exp_q.push_back('{name: "noalarm_s1", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "noalarm_s2", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "noalarm_s3", v: pk(1'b0, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "rescan_s1", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "rescan_s2", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "rescan_s3", v: pk(1'b1, 1'b1, 4'b0001, 8'd1)});
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sensors = stim[i];
      wait_sample(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({err0, alarm0, asens0, cnt0} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h, need %h", e.name, {err0, alarm0, asens0, cnt0}, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   cyc;
    exp_t e;
    do_reset();
    enable  = 1'b1;
    sensors = 4'b0001;
    repeat (3) wait_sample(cyc);
    sensors = 4'b0000;
    wait_sample(cyc);
    ack = 1'b1;
    @(negedge clk);
    ack     = 1'b0;
    sensors = 4'b0001;
    repeat (2) wait_sample(cyc);
    n_checks++;
    if (alarm0 !== 1'b0 || cnt0 !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_pre: alarm=%b cnt=%0d, need alarm=0 cnt=1", alarm0, cnt0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cnt0 !== 8'd0 || alarm0 !== 1'b0 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: cnt=%0d alarm=%b err=%b, need 0/0/0", cnt0, alarm0, err0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{name: "midreset_s1", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "midreset_s2", v: pk(1'b1, 1'b0, 4'd0, 8'd0)});
    exp_q.push_back('{name: "midreset_s3", v: pk(1'b1, 1'b1, 4'b0001, 8'd1)});
    for (int i = 0; i < 3; i++) begin
      wait_sample(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({err0, alarm0, asens0, cnt0} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h, need %h", e.name, {err0, alarm0, asens0, cnt0}, e.v);
      end
    end
  endtask

  task automatic test_sweep();
    int          cyc;
    exp_t        e;
    logic [15:0] mask;
    logic        a;
    logic [7:0]  cnt;
    logic [3:0]  last;
    mask = 16'hEEEA;
    cnt  = 8'd0;
    last = 4'd0;
    do_reset();
    enable = 1'b1;
    for (int v = 0; v < 16; v++) begin
      a = mask[v];
      if (a) begin
        cnt  = cnt + 8'd1;
        last = 4'(v);
      end
      exp_q.push_back('{name: $sformatf("sweep_%0d", v), v: pk(a, a, last, cnt)});
      sensors = 4'(v);
      wait_sample(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if ({err1, alarm1, asens1, cnt1} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h, need %h", e.name, {err1, alarm1, asens1, cnt1}, e.v);
      end
      if (alarm1 === 1'b1) begin
        exp_q.push_back('{name: $sformatf("sweep_clear_%0d", v), v: pk(1'b0, 1'b1, last, cnt)});
        sensors = 4'd0;
        wait_sample(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if ({err1, alarm1, asens1, cnt1} !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h, need %h", e.name, {err1, alarm1, asens1, cnt1}, e.v);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    end
    n_checks++;
    if (cnt1 !== 8'd11 || alarm1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_total: cnt=%0d alarm=%b, need cnt=11 alarm=0", cnt1, alarm1);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sensors = 4'b0001;
      wait_sample(cyc);
      if (i == 254 || i == 255) begin
        n_checks++;
        if (alarm1 !== 1'b1 || cnt1 !== 8'd255) begin
          n_fail++;
          $display("FAIL saturate_entry_%0d: alarm=%b cnt=%0d, need alarm=1 cnt=255", i, alarm1, cnt1);
        end
      end
      sensors = 4'b0000;
      wait_sample(cyc);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    n_checks++;
    if (cnt1 !== 8'd255 || alarm1 !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate_final: cnt=%0d alarm=%b, need cnt=255 alarm=0", cnt1, alarm1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    ack     = 1'b0;
    sensors = 4'd0;
    test_reset();
    test_first_sample();
    test_confirm_alarm();
    test_ack();
    test_ack_on_sample();
    test_no_alarm();
    test_reset_mid();
    test_sweep();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_scan_ctrl.md
SENSOR_SCAN_CTRL -- requirements
Module: sensor_scan_ctrl

Interface
- REQ-001: The block SHALL have parameter PERIOD, default 10: cycles between sensor samples (legal 2..255).
- REQ-002: The block SHALL have parameter CONFIRM, default 3: consecutive error samples needed to raise an alarm (legal 1..15).
- REQ-003: The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
- REQ-004: The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005: The block SHALL have port enable, input, 1 bit: scanning enabled when 1.
- REQ-006: The block SHALL have port sensors, input, 4 bits: raw sensor bank, bit 0 = primary sensor.
- REQ-007: The block SHALL have port ack, input, 1 bit: alarm acknowledge, level-sampled each cycle.
- REQ-008: The block SHALL have port sample_tick, output, 1 bit: one-cycle pulse following each sample edge.
- REQ-009: The block SHALL have port error_now, output, 1 bit: error function of the last sample.
- REQ-010: The block SHALL have port alarm, output, 1 bit: confirmed-fault flag.
- REQ-011: The block SHALL have port alarm_sensors, output, 4 bits: sensor snapshot taken when alarm was raised.
- REQ-012: The block SHALL have port alarm_cnt, output, 8 bits: count of alarm entries, saturating.

Function
- REQ-013: The error function SHALL be err(s) = s[0] | (s[1] & (s[2] | s[3])).
- REQ-014: The timer SHALL advance 0..PERIOD-1 while enable=1 and clear to 0 while enable=0.
- REQ-015: A sample edge SHALL be the edge where timer==PERIOD-1 and enable=1; at that edge the timer returns to 0, error_now<=err(sensors), and sample_tick is 1 for the following cycle.
- REQ-016: The FSM SHALL have states IDLE, SCAN, CONFIRM and ALARM, plus a 4-bit hit counter.
- REQ-017: IDLE -> SCAN when enable=1, with timer starting from 0.
- REQ-018: In SCAN, a sample with err=1 SHALL go to ALARM if CONFIRM==1, else to CONFIRM with hits=1; a sample with err=0 SHALL stay in SCAN.
- REQ-019: In CONFIRM, a sample with err=1 SHALL increment hits and go to ALARM when the new hits value equals CONFIRM; a sample with err=0 SHALL return to SCAN with hits=0.
- REQ-020: Alarm entry SHALL occur at the same edge as the confirming sample: alarm<=1, alarm_sensors<=sensors, alarm_cnt<=alarm_cnt+1 (held at 255 once reached), hits<=0.
- REQ-021: In ALARM, sampling SHALL continue and update error_now only; alarm_sensors SHALL be held.
- REQ-022: ALARM SHALL exit when ack=1 and error_now=0: next state SCAN if enable=1, else IDLE; alarm<=0.
- REQ-023: In ALARM, ack=1 with error_now=1 SHALL be ignored and no ack SHALL be remembered.
- REQ-024: If ack=1 coincides with a sample edge in ALARM, the exit decision SHALL use the error_now value from before that edge.
- REQ-025: enable=0 in SCAN or CONFIRM SHALL go to IDLE next edge, clearing hits and timer.
- REQ-026: enable=0 in ALARM SHALL leave the FSM in ALARM until the exit condition of REQ-022 holds.
- REQ-027: All outputs SHALL be registered.
- REQ-028: There SHALL be no combinational path from inputs to outputs.

Reset
- REQ-029: rst=1 SHALL force immediately, independent of clk: state=IDLE, timer=0, hits=0, sample_tick=0, error_now=0, alarm=0, alarm_sensors=4'b0000, alarm_cnt=0.
- REQ-030: Reset asserted mid-operation (CONFIRM or ALARM) SHALL discard all progress, including alarm_cnt.
- REQ-031: After rst deasserts, the first sample SHALL occur PERIOD edges after the first edge that sees enable=1.

Verification
- REQ-032: Reset check: assert rst asynchronously between edges -> all outputs 0 before the next clk edge.
- REQ-033: With PERIOD=4, CONFIRM=3, sensors=4'b0001, enable=1 -> sample_tick pulses every 4 cycles; alarm=1 after the 3rd sample edge; alarm_sensors=4'b0001; alarm_cnt=1.
- REQ-034: With PERIOD=4, CONFIRM=3, sensors=4'b0110 for 2 samples then 4'b0100 -> error_now sequence 1,1,0; alarm stays 0; FSM back in SCAN.
- REQ-035: In ALARM with sensors=4'b1010, ack=1 -> alarm stays 1; then sensors=4'b0000, and after the next sample ack=1 -> alarm=0 one edge later; alarm_cnt unchanged.
- REQ-036: With CONFIRM=1, sweep sensors 0..15, one sample each, ack between -> alarm raised exactly for {1,3,5,7,9,11,13,15,6,10,14}; alarm_cnt=11.
- REQ-037: Assert rst in CONFIRM with hits=2, then release -> alarm_cnt=0; 3 further error samples are needed before alarm.
